// File: rtl/core_pkg.sv
// Shared definitions for the accumulator core sequencer: state encoding, default widths and
// the enable bundle the FSM drives into the datapath.
package core_pkg;

  localparam int unsigned CntrWidthDefault  = 8;
  localparam int unsigned AddrWidthDefault  = 5;
  localparam int unsigned DataWidthDefault  = 16;
  localparam int unsigned WdogCyclesDefault = 16;
  localparam logic [4:0]  HaltOpDefault     = 5'h1F;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWrite  = 3'd4,
    StHalted = 3'd5,
    StFault  = 3'd6
  } core_state_e;

  typedef struct packed {
    logic rom_req;
    logic ir_we;
    logic acc_we;
    logic reg_we;
    logic pc_ce;
    logic core_rst;
  } core_en_t;

  function automatic logic state_is_busy(core_state_e s);
    return (s == StFetch) || (s == StDecode) || (s == StExec) || (s == StWrite);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch-wait counter: counts cycles spent waiting on ROM and flags the last permitted cycle.
module fetch_watchdog #(
  parameter int unsigned WDOG_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);

  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("fetch_watchdog: WDOG_CYCLES must be >= 1");
  end

  logic [CntW-1:0] count_q, count_d;

  assign tc_o = (count_q == CntW'(WDOG_CYCLES - 1));

  // Saturate at terminal count so a stalled enable can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WRITE controller for the accumulator core, with run/halt/step
// control, a retired-instruction counter and a watchdog on ROM fetches.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned           CNTR_WIDTH  = CntrWidthDefault,
  parameter int unsigned           ADDR_WIDTH  = AddrWidthDefault,
  parameter int unsigned           DATA_WIDTH  = DataWidthDefault,
  parameter logic [ADDR_WIDTH-1:0] HALT_OP     = ADDR_WIDTH'(HaltOpDefault),
  parameter int unsigned           WDOG_CYCLES = WdogCyclesDefault
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  resume,
  input  logic                  step,
  input  logic                  rom_ack,
  input  logic [ADDR_WIDTH-1:0] opcode,
  input  logic                  dec_load,
  input  logic                  dec_store,
  input  logic                  dec_rst_n,
  output logic                  rom_req,
  output logic                  ir_we,
  output logic                  acc_we,
  output logic                  reg_we,
  output logic                  pc_ce,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  halted,
  output logic                  fault,
  output logic [CNTR_WIDTH-1:0] retired_cnt
);

  if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 || CNTR_WIDTH < 1) begin : g_bad_width
    $error("core_sequencer: widths must be >= 1");
  end

  core_state_e           state_q, state_d;
  logic                  step_pending_q, step_pending_d;
  logic [CNTR_WIDTH-1:0] retired_cnt_q, retired_cnt_d;
  core_en_t              en;
  logic                  wdog_clr, wdog_en, wdog_tc;

  fetch_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_fetch_watchdog (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (wdog_clr),
    .en_i  (wdog_en),
    .tc_o  (wdog_tc)
  );

  always_comb begin
    state_d        = state_q;
    step_pending_d = step_pending_q;
    retired_cnt_d  = retired_cnt_q;
    en             = '0;
    wdog_clr       = 1'b1;
    wdog_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
        end
      end

      StFetch: begin
        en.rom_req = 1'b1;
        // An ack on the terminal-count cycle still completes the fetch.
        if (rom_ack) begin
          en.ir_we = 1'b1;
          state_d  = StDecode;
        end else if (wdog_tc) begin
          state_d = StFault;
        end else begin
          wdog_clr = 1'b0;
          wdog_en  = 1'b1;
        end
      end

      StDecode: begin
        if (!dec_rst_n) begin
          en.core_rst    = 1'b1;
          step_pending_d = 1'b0;
          state_d        = StIdle;
        end else if (opcode == HALT_OP) begin
          // HALT_OP neither advances the PC nor retires, so resume re-fetches it.
          step_pending_d = 1'b0;
          state_d        = StHalted;
        end else begin
          state_d = StExec;
        end
      end

      StExec: begin
        en.acc_we = dec_load;
        state_d   = StWrite;
      end

      StWrite: begin
        en.reg_we     = dec_store;
        en.pc_ce      = 1'b1;
        retired_cnt_d = retired_cnt_q + CNTR_WIDTH'(1);
        if (halt_req || step_pending_q) begin
          step_pending_d = 1'b0;
          state_d        = StHalted;
        end else begin
          state_d = StFetch;
        end
      end

      StHalted: begin
        if (step) begin
          step_pending_d = 1'b1;
          state_d        = StFetch;
        end else if (resume && !halt_req) begin
          state_d = StFetch;
        end
      end

      StFault: begin
        state_d = StFault;
      end

      default: begin
        state_d = StFault;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      step_pending_q <= 1'b0;
      retired_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      step_pending_q <= step_pending_d;
      retired_cnt_q  <= retired_cnt_d;
    end
  end

  assign rom_req     = en.rom_req;
  assign ir_we       = en.ir_we;
  assign acc_we      = en.acc_we;
  assign reg_we      = en.reg_we;
  assign pc_ce       = en.pc_ce;
  assign core_rst    = en.core_rst;
  assign busy        = state_is_busy(state_q);
  assign halted      = (state_q == StHalted);
  assign fault       = (state_q == StFault);
  assign retired_cnt = retired_cnt_q;

endmodule
